// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multi-cycle control path: FSM states, opcodes,
// immediate formats, ALU operations and datapath mux selects.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Immediate formats, decoded identically by the immediate generator.
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_U = 3'd1;
    localparam logic [2:0] IMM_J = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_SLT = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_PC4 = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;

    function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_OPIMM:  return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
            OPC_BRANCH: return (f3 == 3'b000) || (f3 == 3'b001);
            OPC_LUI, OPC_JAL, OPC_LOAD, OPC_STORE: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] opimm_alu_op(input logic [2:0] f3);
        case (f3)
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port request/acknowledge handshake between control and memory.
// Request is held until acknowledged; we/iord stay stable while the request is up.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output iord, input mem_ack);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_mem_timeout.sv
// Counts unacknowledged request cycles; expired fires on the TIMEOUT-th waiting cycle.
// Combinational expiry so the FSM leaves the waiting state on that same edge.
module mem_timeout #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB plus absorbing TRAP.
// Enables are decoded from state (Mealy on mem_ack); memory waits stall the FSM until ack or timeout.
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                zero,
    multicycle_ctrl_if.master   mem,
    output logic                ir_we,
    output logic                mdr_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic [2:0]          imm_sel,
    output logic                alu_srcb,
    output logic [2:0]          alu_op,
    output logic                aluout_we,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic                trap,
    output logic                trap_cause
);
    state_t state;
    logic   expired;
    logic   is_store;
    logic   taken;

    assign is_store = (opcode == OPC_STORE);
    assign taken    = funct3[0] ? !zero : zero;

    mem_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!mem.mem_req || mem.mem_ack),
        .en      (mem.mem_req && !mem.mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            trap_cause <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem.mem_ack) begin
                        state <= DECODE;
                    end else if (expired) begin
                        state      <= TRAP;
                        trap_cause <= 1'b1;
                    end
                end
                DECODE: begin
                    if (is_legal(opcode, funct3)) begin
                        state <= EXEC;
                    end else begin
                        state      <= TRAP;
                        trap_cause <= 1'b0;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OPC_JAL, OPC_BRANCH: state <= FETCH;
                        OPC_LOAD, OPC_STORE: state <= MEM;
                        default:             state <= WB;
                    endcase
                end
                MEM: begin
                    if (mem.mem_ack) begin
                        state <= is_store ? FETCH : WB;
                    end else if (expired) begin
                        state      <= TRAP;
                        trap_cause <= 1'b1;
                    end
                end
                WB:      state <= FETCH;
                default: state <= TRAP;
            endcase
        end
    end

    // Reset gates every output so an in-flight request drops immediately.
    always_comb begin
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.iord    = 1'b0;
        ir_we       = 1'b0;
        mdr_we      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        imm_sel     = IMM_I;
        alu_srcb    = 1'b0;
        alu_op      = ALU_ADD;
        aluout_we   = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = WB_ALU;
        retire      = 1'b0;
        trap        = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ack) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                EXEC: begin
                    case (opcode)
                        OPC_OPIMM: begin
                            alu_srcb  = 1'b1;
                            alu_op    = opimm_alu_op(funct3);
                            aluout_we = 1'b1;
                        end
                        OPC_JAL: begin
                            imm_sel = IMM_J;
                            reg_we  = 1'b1;
                            wb_sel  = WB_PC4;
                            pc_we   = 1'b1;
                            pc_sel  = PC_TARGET;
                            retire  = 1'b1;
                        end
                        OPC_BRANCH: begin
                            imm_sel = IMM_B;
                            alu_op  = ALU_SUB;
                            retire  = 1'b1;
                            if (taken) begin
                                pc_we  = 1'b1;
                                pc_sel = PC_TARGET;
                            end
                        end
                        OPC_LOAD, OPC_STORE: begin
                            imm_sel   = is_store ? IMM_S : IMM_I;
                            alu_srcb  = 1'b1;
                            aluout_we = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem.mem_req = 1'b1;
                    mem.iord    = 1'b1;
                    mem.mem_we  = is_store;
                    if (mem.mem_ack) begin
                        retire = is_store;
                        mdr_we = !is_store;
                    end
                end
                WB: begin
                    reg_we = 1'b1;
                    retire = 1'b1;
                    if (opcode == OPC_LOAD) begin
                        wb_sel = WB_MDR;
                    end else if (opcode == OPC_LUI) begin
                        wb_sel  = WB_IMM;
                        imm_sel = IMM_U;
                    end
                end
                TRAP:    trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each instruction class,
// reset during a memory access, illegal-instruction trap and fetch timeout.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       ir_we, mdr_we, pc_we, alu_srcb, aluout_we, reg_we, retire, trap, trap_cause;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] imm_sel, alu_op;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_U  = 7'b0110111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem(mif),
        .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
        .alu_srcb(alu_srcb), .alu_op(alu_op), .aluout_we(aluout_we), .reg_we(reg_we),
        .wb_sel(wb_sel), .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // {req, we, iord, ir_we, mdr_we, pc_we, pc_sel, imm_sel, srcb, alu_op, aluout_we, reg_we, wb_sel, retire}
    wire [31:0] obs = {12'd0, mif.mem_req, mif.mem_we, mif.iord, ir_we, mdr_we, pc_we, pc_sel,
                       imm_sel, alu_srcb, alu_op, aluout_we, reg_we, wb_sel, retire};

    function automatic logic [31:0] o(input int req, input int we, input int iord, input int irwe,
                                      input int mdrwe, input int pcwe, input int pcsel, input int imm,
                                      input int srcb, input int aop, input int aluwe, input int regwe,
                                      input int wbsel, input int ret);
        return {12'd0, 1'(req), 1'(we), 1'(iord), 1'(irwe), 1'(mdrwe), 1'(pcwe), 2'(pcsel),
                3'(imm), 1'(srcb), 3'(aop), 1'(aluwe), 1'(regwe), 2'(wbsel), 1'(ret)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input logic ack, input logic [6:0] opc, input logic [2:0] f3, input logic z);
        @(negedge clk);
        mif.mem_ack = ack;
        opcode      = opc;
        funct3      = f3;
        zero        = z;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        mif.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        mif.mem_ack = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outputs", obs, 32'd0);
        chk("rst.trap", 32'(trap), 32'd0);
        chk("rst.cause", 32'(trap_cause), 32'd0);
        do_reset();

        // addi, acked on first request cycle: 4 cycles
        cyc(1, OP_I, 3'b000, 0); chk("addi.fetch",  obs, o(1,0,0,1,0,1,0,0,0,0,0,0,0,0));
        cyc(0, OP_I, 3'b000, 0); chk("addi.decode", obs, 32'd0);
        cyc(0, OP_I, 3'b000, 0); chk("addi.exec",   obs, o(0,0,0,0,0,0,0,0,1,0,1,0,0,0));
        cyc(0, OP_I, 3'b000, 0); chk("addi.wb",     obs, o(0,0,0,0,0,0,0,0,0,0,0,1,0,1));
        cyc(0, OP_I, 3'b000, 0); chk("addi.refetch", obs, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

        // slti / ori / andi ALU op selection in EXEC
        cyc(1, OP_I, 3'b010, 0); cyc(0, OP_I, 3'b010, 0);
        cyc(0, OP_I, 3'b010, 0); chk("slti.exec", obs, o(0,0,0,0,0,0,0,0,1,2,1,0,0,0));
        cyc(0, OP_I, 3'b010, 0);
        cyc(1, OP_I, 3'b110, 0); cyc(0, OP_I, 3'b110, 0);
        cyc(0, OP_I, 3'b110, 0); chk("ori.exec", obs, o(0,0,0,0,0,0,0,0,1,4,1,0,0,0));
        cyc(0, OP_I, 3'b110, 0);
        cyc(1, OP_I, 3'b111, 0); cyc(0, OP_I, 3'b111, 0);
        cyc(0, OP_I, 3'b111, 0); chk("andi.exec", obs, o(0,0,0,0,0,0,0,0,1,3,1,0,0,0));
        cyc(0, OP_I, 3'b111, 0);

        // beq taken, stray ack in DECODE ignored
        cyc(1, OP_B, 3'b000, 1);
        cyc(1, OP_B, 3'b000, 1); chk("beq.decode_ack", obs, 32'd0);
        cyc(0, OP_B, 3'b000, 1); chk("beq.exec", obs, o(0,0,0,0,0,1,1,3,0,1,0,0,0,1));
        // bne with zero=1 not taken
        cyc(1, OP_B, 3'b001, 1); cyc(0, OP_B, 3'b001, 1);
        cyc(0, OP_B, 3'b001, 1); chk("bne.exec", obs, o(0,0,0,0,0,0,0,3,0,1,0,0,0,1));

        // jal
        cyc(1, OP_J, 3'b000, 0); cyc(0, OP_J, 3'b000, 0);
        cyc(0, OP_J, 3'b000, 0); chk("jal.exec", obs, o(0,0,0,0,0,1,1,2,0,0,0,1,3,1));

        // lui
        cyc(1, OP_U, 3'b000, 0); cyc(0, OP_U, 3'b000, 0);
        cyc(0, OP_U, 3'b000, 0); chk("lui.exec", obs, 32'd0);
        cyc(0, OP_U, 3'b000, 0); chk("lui.wb",   obs, o(0,0,0,0,0,0,0,1,0,0,0,1,2,1));

        // lw with 3 wait cycles in MEM: 8 cycles total
        cyc(1, OP_LW, 3'b010, 0); chk("lw.fetch", obs, o(1,0,0,1,0,1,0,0,0,0,0,0,0,0));
        cyc(0, OP_LW, 3'b010, 0);
        cyc(0, OP_LW, 3'b010, 0); chk("lw.exec", obs, o(0,0,0,0,0,0,0,0,1,0,1,0,0,0));
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, OP_LW, 3'b010, 0);
            if (obs == o(1,0,1,0,0,0,0,0,0,0,0,0,0,0)) n++;
        end
        chk("lw.mem_wait", 32'(n), 32'd3);
        cyc(1, OP_LW, 3'b010, 0); chk("lw.mem_ack", obs, o(1,0,1,0,1,0,0,0,0,0,0,0,0,0));
        cyc(0, OP_LW, 3'b010, 0); chk("lw.wb", obs, o(0,0,0,0,0,0,0,0,0,0,0,1,1,1));

        // sw acked immediately in MEM
        cyc(1, OP_SW, 3'b010, 0); cyc(0, OP_SW, 3'b010, 0);
        cyc(0, OP_SW, 3'b010, 0); chk("sw.exec", obs, o(0,0,0,0,0,0,0,4,1,0,1,0,0,0));
        cyc(1, OP_SW, 3'b010, 0); chk("sw.mem",  obs, o(1,1,1,0,0,0,0,0,0,0,0,0,0,1));
        cyc(0, OP_SW, 3'b010, 0); chk("sw.refetch", obs, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

        // Reset asserted while lw is waiting in MEM
        do_reset();
        cyc(1, OP_LW, 3'b010, 0); cyc(0, OP_LW, 3'b010, 0); cyc(0, OP_LW, 3'b010, 0);
        cyc(0, OP_LW, 3'b010, 0); chk("rstmem.before", obs, o(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rstmem.during", obs, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rstmem.fetch", obs, o(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        n = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, OP_LW, 3'b010, 0);
            if (reg_we || mdr_we) n++;
        end
        chk("rstmem.no_we", 32'(n), 32'd0);
        cyc(1, OP_LW, 3'b010, 0); chk("rstmem.refetch", obs, o(1,0,0,1,0,1,0,0,0,0,0,0,0,0));

        // Illegal R-type opcode traps after DECODE
        do_reset();
        cyc(1, OP_R, 3'b000, 0);
        cyc(0, OP_R, 3'b000, 0); chk("ill.decode_trap", 32'(trap), 32'd0);
        cyc(0, OP_R, 3'b000, 0);
        chk("ill.trap", 32'(trap), 32'd1);
        chk("ill.cause", 32'(trap_cause), 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, OP_R, 3'b000, 0);
            if (obs != 32'd0 || !trap) n++;
        end
        chk("ill.absorb", 32'(n), 32'd0);

        // Branch with unsupported funct3 traps as illegal
        do_reset();
        cyc(1, OP_B, 3'b100, 0); cyc(0, OP_B, 3'b100, 0); cyc(0, OP_B, 3'b100, 0);
        chk("brf3.trap", {30'd0, trap, trap_cause}, 32'd2);

        // Fetch never acknowledged: bus-error trap after 16 request cycles
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, OP_I, 3'b000, 0);
            if (mif.mem_req) n++;
            if (trap) break;
        end
        chk("to.req_cycles", 32'(n), 32'd16);
        chk("to.trap", 32'(trap), 32'd1);
        chk("to.cause", 32'(trap_cause), 32'd1);
        chk("to.req_low", 32'(mif.mem_req), 32'd0);
        cyc(1, OP_I, 3'b000, 0);
        chk("to.absorb", {31'd0, trap}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the RV32I-subset core. It sequences the shared datapath (PC, IR, register file, immediate generator, ALU, single unified memory port) through FETCH/DECODE/EXEC/MEM/WB. It drives the immediate-type select, ALU op, write enables and the memory request/acknowledge handshake. Supported: addi, slti, andi, ori, lui, jal, beq, bne, lw, sw; anything else traps.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay unacknowledged before bus error (2..255)
CNT_W, 8, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  7  IR[6:0] (valid from DECODE onward)
funct3  in  3  IR[14:12]
zero  in  1  ALU result == 0
mem_ack  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until acked
mem_we  out  1  store (valid with mem_req)
iord  out  1  address source: 0=PC, 1=ALUOut
ir_we  out  1  latch IR and old_pc
mdr_we  out  1  latch load data
pc_we  out  1  PC write
pc_sel  out  2  0=PC+4, 1=old_pc+imm (jal/branch)
imm_sel  out  3  immediate format to immediate generator
alu_srcb  out  1  0=rs2, 1=imm
alu_op  out  3  ALU operation code
aluout_we  out  1  latch ALUOut
reg_we  out  1  register-file write
wb_sel  out  2  0=ALUOut, 1=MDR, 2=imm, 3=old_pc+4
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky: illegal instruction or bus error
trap_cause  out  1  0=illegal, 1=bus error

Behaviour:
- Reset (async): state=FETCH, timeout counter=0, trap=0, trap_cause=0; every output 0. Reset mid-transaction drops mem_req in the same cycle; no write enable may pulse.
- Handshake: mem_req stays high until mem_ack is sampled high on a rising edge with mem_req=1. mem_we/iord are stable while mem_req is high. mem_ack with mem_req=0 is ignored.
- Timeout: counter increments each cycle mem_req=1 and mem_ack=0, and clears on ack or state change. Reaching TIMEOUT -> TRAP, trap_cause=1.
- FETCH: mem_req=1, iord=0. On ack (Mealy, same cycle): ir_we=1, pc_we=1, pc_sel=0 -> DECODE.
- DECODE (1 cycle): classify opcode. Unsupported opcode, or branch funct3 not in {000,001} -> TRAP, trap_cause=0.
- EXEC:
  - OP-IMM: alu_srcb=1, imm_sel=I; alu_op from funct3 (000 ADD, 010 SLT, 110 OR, 111 AND; others illegal, detected in DECODE); aluout_we=1 -> WB.
  - LUI: -> WB.
  - JAL: imm_sel=J, reg_we=1, wb_sel=3, pc_we=1, pc_sel=1, retire=1 -> FETCH.
  - BRANCH: imm_sel=B, alu_srcb=0, alu_op=SUB. Taken = (funct3==000)?zero:!zero; if taken, pc_we=1, pc_sel=1. retire=1 -> FETCH.
  - LW/SW: alu_srcb=1, alu_op=ADD, imm_sel=I (lw) or S (sw), aluout_we=1 -> MEM.
- MEM: mem_req=1, iord=1, mem_we=(sw). On ack: sw gives retire=1 -> FETCH; lw gives mdr_we=1 -> WB.
- WB: reg_we=1; wb_sel=0 OP-IMM, 1 LW, 2 LUI (imm_sel=U held); retire=1 -> FETCH.
- TRAP: absorbing until reset; all enables and mem_req are 0, trap=1.
- Write enables and retire are single-cycle pulses. Outputs not listed for a state are 0.
- CPI: OP-IMM/LUI 4+Fw, JAL/BR 3+Fw, SW 4+Fw+Mw, LW 5+Fw+Mw, where Fw/Mw are the cycles spent waiting for mem_ack in FETCH/MEM.

Decomposition:
- Package core_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP)
  - opcode constants (0010011, 0110111, 1101111, 1100011, 0000011, 0100011)
  - imm_sel codes (I=0, U=1, J=2, B=3, S=4), shared with the immediate generator
  - alu_op codes (ADD=0, SUB=1, SLT=2, AND=3, OR=4)
  - wb_sel and pc_sel codes
- One sub-module, mem_timeout: counter with clear/enable, asserts expired at TIMEOUT.

Test Plan:
- Reset while in MEM with mem_req=1 (lw) -> mem_req=0 immediately; state FETCH; no reg_we/mdr_we pulse afterwards until a new fetch is acked.
- addi (opcode 0010011, funct3 000), mem_ack on the first request cycle -> ir_we at cycle 1, aluout_we (imm_sel=0, alu_srcb=1, alu_op=0) at cycle 3, reg_we+retire with wb_sel=0 at cycle 4: 4 cycles total.
- beq with zero=1 then bne with zero=1 -> first: pc_we=1, pc_sel=1; second: pc_we=0. Both retire in EXEC.
- lw with mem_ack delayed 3 cycles in MEM -> mem_req, iord=1 and mem_we=0 held for 4 cycles; mdr_we on the ack cycle; WB wb_sel=1; 8 cycles total.
- Opcode 0110011 -> TRAP after DECODE: trap=1, trap_cause=0; no further mem_req for 20 cycles.
- FETCH with mem_ack never asserted, TIMEOUT=16 -> trap=1, trap_cause=1 after 16 cycles of mem_req; mem_req then 0.
